// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   XON_CHAR / XOFF_CHAR : software flow-control characters decoded by the receiver
//   tx_state_t           : 2-bit encoding of the transmit FIFO output FSM
package uart_pkg;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t S_IDLE    = 2'd0;
    localparam tx_state_t S_FETCH   = 2'd1;
    localparam tx_state_t S_PRESENT = 2'd2;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// synchronous read port (read data appears the cycle after rd_en).
//   clk, reset_n         : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data: write port
//   rd_en/rd_addr        : read request
//   rd_data              : registered read data
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is not reset: emptiness is tracked by the pointers in the top.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of the UART transmitter. Absorbs host bursts and
// presents one byte at a time on a valid/ready handshake; new fetches are
// gated by CTS and XON/XOFF. Reports fill level and a sticky overflow flag.
//   clk, reset_n           : clock, async active-low reset
//   wr_en, wr_data         : host write strobe and byte
//   full, almost_full      : count == DEPTH, count >= AFULL_LVL
//   count                  : bytes held in memory (output register excluded)
//   tx_valid, tx_data      : byte presented to the transmitter
//   tx_ready               : transmitter accepts the byte this cycle
//   cts                    : clear-to-send (already synchronised by caller)
//   xoff_pulse, xon_pulse  : decoded flow-control pulses from the receiver
//   paused                 : XOFF in effect
//   overflow, ovf_clr      : sticky write-while-full flag and its clear
//
// state     | meaning
// S_IDLE    | output register empty, waiting for data + permission
// S_FETCH   | memory read in flight, loading tx_data next edge
// S_PRESENT | tx_valid=1, holding tx_data until tx_ready
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              cts,
    input  logic              xoff_pulse,
    input  logic              xon_pulse,
    output logic              paused,
    output logic              overflow,
    input  logic              ovf_clr
);

    if (DEPTH != 2**ADDR_W) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must equal 2**ADDR_W");
    end
    if (AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("uart_tx_fifo: AFULL_LVL must not exceed DEPTH");
    end

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    tx_state_t         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_accept;
    logic              can_fetch;
    logic              rd_issue;

    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AFULL_C);
    assign wr_accept   = wr_en && !full;
    assign can_fetch   = (count != '0) && cts && !paused;

    // A read is issued from IDLE, or back-to-back from PRESENT on a transfer.
    assign rd_issue = can_fetch &&
                      ((state == S_IDLE) || ((state == S_PRESENT) && tx_ready));

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_accept, rd_issue})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (can_fetch) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    tx_data  <= rd_data;
                    tx_valid <= 1'b1;
                    state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    // Gating only blocks new fetches; a presented byte waits for tx_ready.
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= can_fetch ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            paused   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (xoff_pulse) begin
                paused <= 1'b1;
            end else if (xon_pulse) begin
                paused <= 1'b0;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard checked on every
// tx_valid && tx_ready transfer.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       cts;
    logic       xoff_pulse;
    logic       xon_pulse;
    logic       paused;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_tx_fifo dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .cts         (cts),
        .xoff_pulse  (xoff_pulse),
        .xon_pulse   (xon_pulse),
        .paused      (paused),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a transfer happens on the next rising edge when both are high.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (tx_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, tx_valid}, 1);
    endtask

    initial begin
        int sent;
        int guard;
        logic [7:0] b;

        reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b1;
        cts = 1'b1; xoff_pulse = 1'b0; xon_pulse = 1'b0; ovf_clr = 1'b0;
        #12;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_afull", {31'd0, almost_full}, 0);
        chk("rst_paused", {31'd0, paused}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // 1: single byte latency
        push(8'hA5);
        chk("t1_cnt_e1", {27'd0, count}, 1);
        chk("t1_valid_e1", {31'd0, tx_valid}, 0);
        tick();
        chk("t1_valid_e2", {31'd0, tx_valid}, 0);
        chk("t1_cnt_e2", {27'd0, count}, 0);
        tick();
        chk("t1_valid_e3", {31'd0, tx_valid}, 1);
        chk("t1_data_e3", {24'd0, tx_data}, 32'hA5);
        tick();
        chk("t1_valid_after", {31'd0, tx_valid}, 0);
        chk("t1_q", q.size(), 0);

        // 2: fill, full, overflow, drain order
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int e;
            push(8'(i));
            e = (i == 0) ? 1 : i;
            chk("t2_count", {27'd0, count}, e);
            chk("t2_afull", {31'd0, almost_full}, (e >= 12) ? 1 : 0);
            chk("t2_full", {31'd0, full}, (e == 16) ? 1 : 0);
        end
        chk("t2_head_valid", {31'd0, tx_valid}, 1);
        chk("t2_head_data", {24'd0, tx_data}, 0);
        push(8'h10);
        chk("t2_count16", {27'd0, count}, 16);
        chk("t2_full16", {31'd0, full}, 1);
        chk("t2_ovf_pre", {31'd0, overflow}, 0);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        chk("t2_ovf_set", {31'd0, overflow}, 1);
        chk("t2_count_hold", {27'd0, count}, 16);
        ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("t2_ovf_setwins", {31'd0, overflow}, 1);
        tx_ready = 1'b1;
        wait_empty("t2_drain", 100);
        chk("t2_count_end", {27'd0, count}, 0);
        chk("t2_valid_end", {31'd0, tx_valid}, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t2_ovf_clr", {31'd0, overflow}, 0);

        // 3: cts drop while presenting
        tx_ready = 1'b0;
        push(8'h31);
        push(8'h32);
        wait_valid("t3_valid", 10);
        cts = 1'b0;
        tick(); tick(); tick();
        chk("t3_hold_valid", {31'd0, tx_valid}, 1);
        chk("t3_hold_data", {24'd0, tx_data}, 32'h31);
        tx_ready = 1'b1;
        tick();
        tick(); tick(); tick();
        chk("t3_no_fetch", {31'd0, tx_valid}, 0);
        chk("t3_count", {27'd0, count}, 1);
        cts = 1'b1;
        wait_empty("t3_drain", 20);

        // 4: XON/XOFF
        tx_ready = 1'b0;
        cts = 1'b0;
        push(8'h41); push(8'h42); push(8'h43);
        xoff_pulse = 1'b1;
        tick();
        xoff_pulse = 1'b0;
        cts = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t4_paused", {31'd0, paused}, 1);
        chk("t4_no_valid", {31'd0, tx_valid}, 0);
        chk("t4_count", {27'd0, count}, 3);
        tx_ready = 1'b1;
        xon_pulse = 1'b1;
        tick();
        xon_pulse = 1'b0;
        chk("t4_resumed", {31'd0, paused}, 0);
        wait_empty("t4_drain", 30);
        xon_pulse = 1'b1; xoff_pulse = 1'b1;
        tick();
        xon_pulse = 1'b0; xoff_pulse = 1'b0;
        chk("t4_xoff_wins", {31'd0, paused}, 1);
        xon_pulse = 1'b1;
        tick();
        xon_pulse = 1'b0;
        chk("t4_unpause", {31'd0, paused}, 0);

        // 5: random traffic across pointer wrap
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 2000) begin
            tx_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && full == 1'b0) begin
                b = 8'($urandom);
                wr_en = 1'b1;
                wr_data = b;
                q.push_back(b);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            guard++;
        end
        wr_en = 1'b0;
        chk("t5_sent", sent, 40);
        tx_ready = 1'b1;
        wait_empty("t5_drain", 200);
        chk("t5_count", {27'd0, count}, 0);

        // 6: async reset during S_FETCH
        tx_ready = 1'b0;
        cts = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        chk("t6_count6", {27'd0, count}, 6);
        cts = 1'b1;
        tick();
        chk("t6_count5", {27'd0, count}, 5);
        chk("t6_fetch_valid", {31'd0, tx_valid}, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("t6_rst_count", {27'd0, count}, 0);
        chk("t6_rst_valid", {31'd0, tx_valid}, 0);
        chk("t6_rst_data", {24'd0, tx_data}, 0);
        chk("t6_rst_full", {31'd0, full}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_post_valid", {31'd0, tx_valid}, 0);
        chk("t6_post_count", {27'd0, count}, 0);
        tx_ready = 1'b1;
        push(8'h77);
        wait_empty("t6_fresh", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
